tt_sweep_checker: RTL and testbench



---
 rtl/tt_sweep_checker.sv | 182 ++++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: exhaustive stimulus engine for small combinational DUTs.
// Walks every N_IN-bit input vector in ascending order, holds each one for
// HOLD clocks and, on the last hold cycle, compares dut_out against exp_out.
// Mismatching vectors are counted and the first offending vector is kept.
// Optional feature macro TT_SWEEP_CONTINUOUS_EN: the sweep wraps back to
// vector 0 forever, pulsing done once per pass and saturating err_count.
module tt_sweep_checker #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int HOLD  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  dut_out,
    input  logic [N_OUT-1:0]  exp_out,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     err_count,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_vec
);

    // A one-cycle hold still needs a 1-bit counter so the widths stay legal.
    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
`ifdef TT_SWEEP_CONTINUOUS_EN
    localparam logic [N_IN:0]   ERR_MAX   = {(N_IN+1){1'b1}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [N_IN-1:0]    vec_r, vec_s;
    logic [HC_W-1:0]    hold_cnt_r, hold_cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [N_IN:0]      err_r, err_s;
    logic               fev_valid_r, fev_valid_s;
    logic [N_IN-1:0]    fev_r, fev_s;
    logic               mismatch_s;

    // Exact full-width equality between the DUT and the golden response.
    function automatic logic vec_mismatch(input logic [N_OUT-1:0] a,
                                          input logic [N_OUT-1:0] b);
        return (a != b);
    endfunction

    // Same-cycle compare; the DUT is expected to settle within HOLD clocks.
    always_comb begin
        mismatch_s = vec_mismatch(dut_out, exp_out);
    end

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        state_s     = state_r;
        vec_s       = vec_r;
        hold_cnt_s  = hold_cnt_r;
        busy_s      = busy_r;
        done_s      = done_r;
        err_s       = err_r;
        fev_valid_s = fev_valid_r;
        fev_s       = fev_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    // abort beats a simultaneous start
                    state_s    = ST_IDLE;
                    busy_s     = 1'b0;
                    done_s     = 1'b0;
                    vec_s      = {N_IN{1'b0}};
                    hold_cnt_s = {HC_W{1'b0}};
                end else if (start) begin
                    state_s     = ST_RUN;
                    vec_s       = {N_IN{1'b0}};
                    hold_cnt_s  = {HC_W{1'b0}};
                    busy_s      = 1'b1;
                    done_s      = 1'b0;
                    err_s       = {(N_IN+1){1'b0}};
                    fev_valid_s = 1'b0;
                    fev_s       = {N_IN{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
`ifdef TT_SWEEP_CONTINUOUS_EN
                // done is a single-cycle per-pass pulse in this mode
                done_s = 1'b0;
`endif
                if (abort) begin
                    // results so far stay visible; the pending compare is dropped
                    state_s    = ST_IDLE;
                    busy_s     = 1'b0;
                    done_s     = 1'b0;
                    vec_s      = {N_IN{1'b0}};
                    hold_cnt_s = {HC_W{1'b0}};
                end else if (hold_cnt_r != HOLD_LAST) begin
                    hold_cnt_s = hold_cnt_r + HC_W'(1'b1);
                end else begin
                    hold_cnt_s = {HC_W{1'b0}};
                    if (mismatch_s) begin
`ifdef TT_SWEEP_CONTINUOUS_EN
                        if (err_r != ERR_MAX) begin
                            err_s = err_r + (N_IN+1)'(1'b1);
                        end else begin
                            err_s = err_r;
                        end
`else
                        err_s = err_r + (N_IN+1)'(1'b1);
`endif
                        if (!fev_valid_r) begin
                            fev_valid_s = 1'b1;
                            fev_s       = vec_r;
                        end else begin
                            fev_valid_s = fev_valid_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                    if (vec_r == VEC_LAST) begin
`ifdef TT_SWEEP_CONTINUOUS_EN
                        vec_s  = {N_IN{1'b0}};
                        done_s = 1'b1;
`else
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
`endif
                    end else begin
                        vec_s = vec_r + N_IN'(1'b1);
                    end
                end
            end
            default: begin
                state_s    = ST_IDLE;
                busy_s     = 1'b0;
                done_s     = 1'b0;
                vec_s      = {N_IN{1'b0}};
                hold_cnt_s = {HC_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset discards any partial sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            vec_r       <= {N_IN{1'b0}};
            hold_cnt_r  <= {HC_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= {(N_IN+1){1'b0}};
            fev_valid_r <= 1'b0;
            fev_r       <= {N_IN{1'b0}};
        end else begin
            state_r     <= state_s;
            vec_r       <= vec_s;
            hold_cnt_r  <= hold_cnt_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            fev_valid_r <= fev_valid_s;
            fev_r       <= fev_s;
        end
    end

    assign vec_out         = vec_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err_count       = err_r;
    assign first_err_valid = fev_valid_r;
    assign first_err_vec   = fev_r;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: a default instance (N_IN=3, HOLD=5)
// driving a majority-gate golden model with selectable faults, plus a small
// HOLD=1, N_IN=2 instance for the single-cycle-hold boundary.
module tb_tt_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] vec_out;
    logic [0:0] dut_out, exp_out;
    logic       busy, done, first_err_valid;
    logic [3:0] err_count;
    logic [2:0] first_err_vec;
    int         mode = 0;

    logic       start2 = 1'b0;
    logic       abort2 = 1'b0;
    logic [1:0] vec2, dut2, exp2;
    logic       busy2, done2, fv2;
    logic [2:0] err2;
    logic [1:0] fev2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // golden: 3-input majority; fault modes: 1 = vec 5 only, 2 = all, 3 = vec >= 1
    assign exp_out = (vec_out[0] & vec_out[1]) | (vec_out[0] & vec_out[2]) | (vec_out[1] & vec_out[2]);
    assign dut_out = exp_out ^ ((mode == 2) || (mode == 1 && vec_out == 3'd5) || (mode == 3 && vec_out >= 3'd1));
    assign exp2    = {vec2[0], ^vec2};
    assign dut2    = exp2;

    tt_sweep_checker #(.N_IN(3), .N_OUT(1), .HOLD(5)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec_out(vec_out), .dut_out(dut_out), .exp_out(exp_out),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
    );

    tt_sweep_checker #(.N_IN(2), .N_OUT(2), .HOLD(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .vec_out(vec2), .dut_out(dut2), .exp_out(exp2),
        .busy(busy2), .done(done2), .err_count(err2),
        .first_err_valid(fv2), .first_err_vec(fev2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start a sweep and wait (bounded) for done; edges counted after the start edge
    task automatic run_sweep();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq("latency", n, 40);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_vec", vec_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err_count, 0);
        check_eq("rst_fev_valid", first_err_valid, 0);
        check_eq("rst_fev", first_err_vec, 0);
        rst = 1'b0;

`ifndef TT_SWEEP_CONTINUOUS_EN
        // clean sweep: vec steps every 5 clocks, done at edge 40
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t1_busy0", busy, 1);
        check_eq("t1_vec0", vec_out, 0);
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e < 40) begin
                check_eq("t1_vec", vec_out, e / 5);
                check_eq("t1_busy", busy, 1);
            end else begin
                check_eq("t1_done", done, 1);
                check_eq("t1_busy_end", busy, 0);
                check_eq("t1_vec_end", vec_out, 7);
            end
        end
        check_eq("t1_err", err_count, 0);
        check_eq("t1_fev_valid", first_err_valid, 0);

        // single mismatch at vector 5, started from DONE
        mode = 1;
        run_sweep();
        check_eq("t2_err", err_count, 1);
        check_eq("t2_fev_valid", first_err_valid, 1);
        check_eq("t2_fev", first_err_vec, 5);

        // every vector mismatches
        mode = 2;
        run_sweep();
        check_eq("t3_err", err_count, 8);
        check_eq("t3_fev", first_err_vec, 0);

        // abort on edge 12 (vector 2) after a mismatch at vector 1
        mode = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        check_eq("t4_vec_pre", vec_out, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t4_busy", busy, 0);
        check_eq("t4_done", done, 0);
        check_eq("t4_vec", vec_out, 0);
        check_eq("t4_err", err_count, 1);
        check_eq("t4_fev", first_err_vec, 1);
        // start together with abort: abort wins, results untouched
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("t4b_busy", busy, 0);
        check_eq("t4b_err", err_count, 1);

        // abort on the final sample cycle discards that compare
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        check_eq("t6_vec7", vec_out, 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t6_done", done, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_err", err_count, 7);

        // start while busy ignored, then async reset mid-sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t5_vec", vec_out, 4);
        check_eq("t5_busy", busy, 1);
        check_eq("t5_err", err_count, 4);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_vec", vec_out, 0);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_err", err_count, 0);
        check_eq("t5_rst_fev_valid", first_err_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        run_sweep();
        check_eq("t5_after_err", err_count, 0);

        // HOLD=1, N_IN=2: one vector per clock, done at edge 4
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e < 4) begin
                check_eq("h1_vec", vec2, e);
                check_eq("h1_done", done2, 0);
            end else begin
                check_eq("h1_done_end", done2, 1);
                check_eq("h1_busy_end", busy2, 0);
                check_eq("h1_err", err2, 0);
            end
        end
`else
        // continuous: done pulses on every 4th edge, busy stays high
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check_eq("c_done", done2, (e % 4 == 0) ? 1 : 0);
            check_eq("c_busy", busy2, 1);
            check_eq("c_vec", vec2, e % 4);
        end
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        check_eq("c_abort_busy", busy2, 0);
        check_eq("c_abort_done", done2, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
